// File: rtl/layer_alloc_engine.sv
// layer_alloc_engine: parses a layer-descriptor packet from packet memory and
// bump-allocates SCR/SGRAD/WGRAD/BGRAD regions for every layer plus a trailing
// MSE stage, emitting one allocation record per region over valid/ready.
// Optional feature macro: LAE_ALIGN4_EN (round each region begin up to 4).
module layer_alloc_engine #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 32,
  parameter int NUM_POOLS    = 2,
  parameter int SCRATCH_POOL = 1,
  parameter int MAX_LAYERS   = 16
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          pool_init,
  input  logic [NUM_POOLS*ADDR_W-1:0]   pool_base,
  input  logic [NUM_POOLS*ADDR_W-1:0]   pool_end,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             pkt_base,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_done,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [2:0]                    rec_kind,
  output logic [$clog2(MAX_LAYERS+1)-1:0] rec_layer,
  output logic [1:0]                    rec_op,
  output logic [$clog2(NUM_POOLS):0]    rec_pool,
  output logic [ADDR_W-1:0]             rec_begin,
  output logic [ADDR_W-1:0]             rec_end,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code
);
  localparam int LW = $clog2(MAX_LAYERS+1);
  localparam int PW = $clog2(NUM_POOLS) + 1;
  localparam int SW = ADDR_W + 1;
  localparam int XW = ADDR_W + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_RD_OP, S_RD_OUT, S_RD_IN, S_ALLOC, S_EMIT, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LW-1:0]       cnt_q, cnt_d, layer_q, layer_d;
  logic [1:0]          op_q, op_d;
  logic [15:0]         out_q, out_d, in_q, in_d;
  logic [2:0]          kind_q, kind_d;
  logic [PW-1:0]       pool_q, pool_d;
  logic [ADDR_W-1:0]   beg_q, beg_d, end_q, end_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W-1:0]   avail_q [NUM_POOLS];
  logic [ADDR_W-1:0]   lim_q   [NUM_POOLS];

  logic [31:0]         prod, raw;
  logic [SW-1:0]       size;
  logic [XW-1:0]       beg_s, end_s, beg_0, end_0;
  logic                fit_s, fit_0, use_s, fit_any, last_region;

  // Oversized products clamp to all-ones so they can never pass the fit check.
  function automatic logic [SW-1:0] sat_size(input logic [31:0] v);
    if ((v >> SW) != 32'd0) return '1;
    return v[SW-1:0];
  endfunction

  function automatic logic [XW-1:0] align_up(input logic [ADDR_W-1:0] a);
`ifdef LAE_ALIGN4_EN
    return (XW'(a) + XW'(3)) & ~XW'(3);
`else
    return XW'(a);
`endif
  endfunction

  // Region size for the current kind, then fit checks on scratch pool and pool 0.
  always_comb begin
    prod = 32'(in_q) * 32'(out_q);
    raw  = 32'(out_q) + 32'd3;
    case (kind_q)
      3'd1:    raw = 32'(in_q) + 32'd3;
      3'd2:    raw = prod + 32'd4;
      default: raw = 32'(out_q) + 32'd3;
    endcase
    size    = sat_size(raw);
    beg_s   = align_up(avail_q[SCRATCH_POOL]);
    end_s   = beg_s + XW'(size);
    fit_s   = end_s <= XW'(lim_q[SCRATCH_POOL]);
    beg_0   = align_up(avail_q[0]);
    end_0   = beg_0 + XW'(size);
    fit_0   = end_0 <= XW'(lim_q[0]);
    use_s   = (kind_q < 3'd2) && fit_s;
    fit_any = use_s || fit_0;
    last_region = (op_q == 2'd1) ? (kind_q == 3'd3) : (kind_q == 3'd1);
  end

  // Next-state and datapath-update logic for the parse/allocate FSM.
  always_comb begin
    state_d  = state_q;
    rd_req_d = rd_req_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    layer_d  = layer_q;
    op_d     = op_q;
    out_d    = out_q;
    in_d     = in_q;
    kind_d   = kind_q;
    pool_d   = pool_q;
    beg_d    = beg_q;
    end_d    = end_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = pkt_base;
          err_d   = 1'b0;
          code_d  = 2'd0;
          out_d   = '0;
          in_d    = '0;
          layer_d = '0;
          kind_d  = '0;
          state_d = S_RD_CNT;
        end
      end
      S_RD_CNT, S_RD_OP, S_RD_OUT, S_RD_IN: begin
        if (!rd_req_q) begin
          rd_req_d = 1'b1;
        end else if (rd_done) begin
          rd_req_d = 1'b0;
          addr_d   = addr_q + ADDR_W'(1);
          case (state_q)
            S_RD_CNT: begin
              if (rd_data == '0 || rd_data > DATA_W'(MAX_LAYERS)) begin
                err_d   = 1'b1;
                code_d  = 2'd1;
                state_d = S_ERR;
              end else begin
                cnt_d   = rd_data[LW-1:0];
                state_d = S_RD_OP;
              end
            end
            S_RD_OP: begin
              if (rd_data == DATA_W'(1)) begin
                op_d    = 2'd1;
                state_d = S_RD_OUT;
              end else if (rd_data == DATA_W'(3)) begin
                op_d    = 2'd3;
                in_d    = out_q;
                kind_d  = '0;
                state_d = S_ALLOC;
              end else begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_ERR;
              end
            end
            S_RD_OUT: begin
              out_d   = rd_data[15:0];
              state_d = S_RD_IN;
            end
            default: begin
              in_d    = rd_data[15:0];
              kind_d  = '0;
              state_d = S_ALLOC;
            end
          endcase
        end
      end
      S_ALLOC: begin
        if (fit_any) begin
          pool_d  = use_s ? PW'(SCRATCH_POOL) : '0;
          beg_d   = use_s ? beg_s[ADDR_W-1:0] : beg_0[ADDR_W-1:0];
          end_d   = use_s ? end_s[ADDR_W-1:0] : end_0[ADDR_W-1:0];
          state_d = S_EMIT;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_ERR;
        end
      end
      S_EMIT: begin
        if (rec_ready) begin
          if (!last_region) begin
            kind_d  = kind_q + 3'd1;
            state_d = S_ALLOC;
          end else if (op_q == 2'd2) begin
            state_d = S_DONE;
          end else if (layer_q + LW'(1) == cnt_q) begin
            op_d    = 2'd2;
            layer_d = cnt_q;
            in_d    = out_q;
            kind_d  = '0;
            state_d = S_ALLOC;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = S_RD_OP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and record registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      rd_req_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      layer_q  <= '0;
      op_q     <= '0;
      out_q    <= '0;
      in_q     <= '0;
      kind_q   <= '0;
      pool_q   <= '0;
      beg_q    <= '0;
      end_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      layer_q  <= layer_d;
      op_q     <= op_d;
      out_q    <= out_d;
      in_q     <= in_d;
      kind_q   <= kind_d;
      pool_q   <= pool_d;
      beg_q    <= beg_d;
      end_q    <= end_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Pool pointers: rewound by pool_init in IDLE, bumped on each accepted record.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        avail_q[i] <= '0;
        lim_q[i]   <= '0;
      end
    end else if (state_q == S_IDLE && pool_init) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        avail_q[i] <= pool_base[i*ADDR_W +: ADDR_W];
        lim_q[i]   <= pool_end[i*ADDR_W +: ADDR_W];
      end
    end else if (state_q == S_EMIT && rec_ready) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        if (pool_q == PW'(i)) avail_q[i] <= end_q;
      end
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = addr_q;
  assign rec_valid = (state_q == S_EMIT);
  assign rec_kind  = kind_q;
  assign rec_layer = layer_q;
  assign rec_op    = op_q;
  assign rec_pool  = pool_q;
  assign rec_begin = beg_q;
  assign rec_end   = end_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign err       = err_q;
  assign err_code  = code_q;
endmodule
